// File: rtl/hazard_ctrl_v.sv
// hazard_ctrl_v: pipeline hazard controller (branch flush, refill bubbles, load-use stall, external hold)
module hazard_ctrl_v #(
  parameter int REFILL_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ext_hold,
  output logic             is_flush,
  output logic             is_stall,
  output logic [31:0]      branch_target,
  output logic             kill_id_ex,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] stall_count
);
  typedef enum logic [2:0] {RUN, FLUSH, REFILL, LU_STALL, HOLD} state_t;
  localparam logic [1:0] RC = 2'(REFILL_CYCLES);
  state_t state, state_nx;
  logic [1:0] rcnt, rcnt_nx;
  logic taken, lu_hazard;
  assign taken = ex_valid & ex_branch_taken;
  assign lu_hazard = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  // Moore outputs: decoded from the registered state only
  assign is_flush = state == FLUSH;
  assign is_stall = (state == LU_STALL) | (state == HOLD);
  assign kill_id_ex = (state == FLUSH) | (state == REFILL) | (state == LU_STALL);
  // next state; FLUSH and REFILL ignore all requests since they carry wrong-path bubbles
  always_comb begin
    state_nx = state;
    rcnt_nx = rcnt;
    case (state)
      RUN:      state_nx = taken ? FLUSH : ext_hold ? HOLD : lu_hazard ? LU_STALL : RUN;
      FLUSH: begin
        state_nx = (RC == 2'd0) ? RUN : REFILL;
        rcnt_nx = RC;
      end
      REFILL: begin
        state_nx = (rcnt <= 2'd1) ? RUN : REFILL;
        rcnt_nx = (rcnt == 2'd0) ? 2'd0 : rcnt - 2'd1;
      end
      LU_STALL: state_nx = taken ? FLUSH : RUN;
      HOLD:     state_nx = taken ? FLUSH : ext_hold ? HOLD : RUN;
      default:  state_nx = RUN;
    endcase
  end
  // state, redirect latch and saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      rcnt <= 2'd0;
      branch_target <= 32'd0;
      flush_count <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      rcnt <= rcnt_nx;
      if (state_nx == FLUSH) branch_target <= ex_target;
      if (is_flush && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
      if (is_stall && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_v.sv
// tb_hazard_ctrl_v: scoreboard bench for hazard_ctrl_v with directed vectors
module tb_hazard_ctrl_v;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ex_valid = 1'b0, ex_branch_taken = 1'b0, ex_is_load = 1'b0;
  logic [31:0] ex_target = 32'd0;
  logic [4:0] ex_rd = 5'd0, id_rs1 = 5'd3, id_rs2 = 5'd0;
  logic id_valid = 1'b1, id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b1, ext_hold = 1'b0;
  logic is_flush, is_stall, kill_id_ex, is_flush4, is_stall4, kill4;
  logic [31:0] branch_target, bt4;
  logic [15:0] flush_count, stall_count;
  logic [3:0] fc4, sc4;

  typedef struct packed {
    logic f, s, k;
    logic [31:0] bt;
    logic [15:0] fc, sc;
    logic [3:0] sc4;
  } exp_t;

  exp_t q[$];
  string qn[$];
  int nchk = 0, npass = 0;

  always #5 clk = ~clk;

  hazard_ctrl_v #(.REFILL_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch_taken(ex_branch_taken),
    .ex_target(ex_target), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ext_hold(ext_hold), .is_flush(is_flush), .is_stall(is_stall), .branch_target(branch_target),
    .kill_id_ex(kill_id_ex), .flush_count(flush_count), .stall_count(stall_count));

  hazard_ctrl_v #(.REFILL_CYCLES(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch_taken(ex_branch_taken),
    .ex_target(ex_target), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ext_hold(ext_hold), .is_flush(is_flush4), .is_stall(is_stall4), .branch_target(bt4),
    .kill_id_ex(kill4), .flush_count(fc4), .stall_count(sc4));

  task automatic cyc(input string nm, input logic rv, input logic br, input logic [31:0] tg,
                     input logic ld, input logic [4:0] rd, input logic [4:0] rs2, input logic hold,
                     input logic ef, input logic es, input logic ek, input logic [31:0] ebt,
                     input logic [15:0] efc, input logic [15:0] esc, input logic [3:0] esc4);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rv;
    ex_valid = br | ld;
    ex_branch_taken = br;
    ex_target = tg;
    ex_is_load = ld;
    ex_rd = rd;
    id_rs2 = rs2;
    ext_hold = hold;
    e.f = ef; e.s = es; e.k = ek; e.bt = ebt; e.fc = efc; e.sc = esc; e.sc4 = esc4;
    q.push_back(e);
    qn.push_back(nm);
  endtask

  initial begin
    exp_t e;
    string n;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n = qn.pop_front();
        nchk++;
        if ({is_flush, is_stall, kill_id_ex, branch_target, flush_count, stall_count, sc4} !== e)
          $display("FAIL %s: got f=%b s=%b k=%b bt=%h fc=%0d sc=%0d sc4=%0d exp f=%b s=%b k=%b bt=%h fc=%0d sc=%0d sc4=%0d",
                   n, is_flush, is_stall, kill_id_ex, branch_target, flush_count, stall_count, sc4,
                   e.f, e.s, e.k, e.bt, e.fc, e.sc, e.sc4);
        else npass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, exp finish");
    $fatal(1);
  end

  initial begin
    cyc("rst",        0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0,       0, 0, 0);
    cyc("idle",       1, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0,       0, 0, 0);
    cyc("a_run",      1, 1, 'h40,    0, 0, 0, 0,  0, 0, 0, 0,       0, 0, 0);
    cyc("a_flush",    1, 0, 0,       0, 0, 0, 0,  1, 0, 1, 'h40,    0, 0, 0);
    cyc("a_refill",   1, 0, 0,       0, 0, 0, 0,  0, 0, 1, 'h40,    1, 0, 0);
    cyc("a_run2",     1, 0, 0,       0, 0, 0, 0,  0, 0, 0, 'h40,    1, 0, 0);
    cyc("b_ld",       1, 0, 0,       1, 5, 5, 0,  0, 0, 0, 'h40,    1, 0, 0);
    cyc("b_stall",    1, 0, 0,       0, 0, 0, 0,  0, 1, 1, 'h40,    1, 0, 0);
    cyc("b_ld_r0",    1, 0, 0,       1, 0, 0, 0,  0, 0, 0, 'h40,    1, 1, 1);
    cyc("b_nostall",  1, 0, 0,       0, 0, 0, 0,  0, 0, 0, 'h40,    1, 1, 1);
    cyc("c_run",      1, 0, 0,       0, 0, 0, 1,  0, 0, 0, 'h40,    1, 1, 1);
    cyc("c_hold1",    1, 0, 0,       0, 0, 0, 1,  0, 1, 0, 'h40,    1, 1, 1);
    cyc("c_hold2",    1, 0, 0,       0, 0, 0, 1,  0, 1, 0, 'h40,    1, 2, 2);
    cyc("c_hold3",    1, 0, 0,       0, 0, 0, 1,  0, 1, 0, 'h40,    1, 3, 3);
    cyc("c_hold4_br", 1, 1, 'h80,    0, 0, 0, 1,  0, 1, 0, 'h40,    1, 4, 4);
    cyc("c_flush",    1, 0, 0,       0, 0, 0, 0,  1, 0, 1, 'h80,    1, 5, 5);
    cyc("c_refill_br",1, 1, 'hC0,    0, 0, 0, 0,  0, 0, 1, 'h80,    2, 5, 5);
    cyc("c_run2",     1, 0, 0,       0, 0, 0, 0,  0, 0, 0, 'h80,    2, 5, 5);
    cyc("d_both",     1, 1, 'h100,   1, 7, 7, 0,  0, 0, 0, 'h80,    2, 5, 5);
    cyc("d_flush",    1, 0, 0,       0, 0, 0, 0,  1, 0, 1, 'h100,   2, 5, 5);
    cyc("d_refill",   1, 0, 0,       0, 0, 0, 0,  0, 0, 1, 'h100,   3, 5, 5);
    cyc("d_run",      1, 0, 0,       0, 0, 0, 0,  0, 0, 0, 'h100,   3, 5, 5);
    cyc("e_ld",       1, 0, 0,       1, 9, 9, 0,  0, 0, 0, 'h100,   3, 5, 5);
    cyc("e_stall_br", 1, 1, 'h200,   0, 0, 0, 0,  0, 1, 1, 'h100,   3, 5, 5);
    cyc("e_flush",    1, 0, 0,       0, 0, 0, 0,  1, 0, 1, 'h200,   3, 6, 6);
    cyc("e_refill",   1, 0, 0,       0, 0, 0, 0,  0, 0, 1, 'h200,   4, 6, 6);
    cyc("e_run",      1, 0, 0,       0, 0, 0, 0,  0, 0, 0, 'h200,   4, 6, 6);
    cyc("s_rst",      0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0,       0, 0, 0);
    cyc("s_run",      1, 0, 0,       0, 0, 0, 1,  0, 0, 0, 0,       0, 0, 0);
    for (int k = 0; k < 20; k++)
      cyc($sformatf("s_hold%0d", k), 1, 0, 0, 0, 0, 0, k < 19, 0, 1, 0, 0, 0, 16'(k),
          (k > 15) ? 4'hF : 4'(k));
    cyc("s_end",      1, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0,       0, 20, 15);
    cyc("f_br",       1, 1, 'h44,    0, 0, 0, 0,  0, 0, 0, 0,       0, 20, 15);
    cyc("f_flush",    1, 0, 0,       0, 0, 0, 0,  1, 0, 1, 'h44,    0, 20, 15);
    cyc("f_rst_refill",0,0, 0,       0, 0, 0, 0,  0, 0, 0, 0,       0, 0, 0);
    cyc("f_rel_br",   1, 1, 'h48,    0, 0, 0, 0,  0, 0, 0, 0,       0, 0, 0);
    cyc("f_flush2",   1, 0, 0,       0, 0, 0, 0,  1, 0, 1, 'h48,    0, 0, 0);
    cyc("f_refill2",  1, 0, 0,       0, 0, 0, 0,  0, 0, 1, 'h48,    1, 0, 0);
    cyc("f_run",      1, 0, 0,       0, 0, 0, 0,  0, 0, 0, 'h48,    1, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      nchk++;
      $display("FAIL drain: got %0d pending, exp 0", q.size());
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
